// File: rtl/factorial_engine_if.sv
// Request/response handshake bundle for the factorial engine.
// The master issues operands and consumes results; the slave is the engine.
interface factorial_engine_if #(
  parameter int WIDTH = 32,
  parameter int NW    = 6
);
  logic             in_valid;
  logic             in_ready;
  logic [NW-1:0]    in_n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_n, out_ready,
    input  in_ready, out_valid, out_result, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_n, out_ready,
    output in_ready, out_valid, out_result, out_ovf, busy
  );
endinterface

// File: rtl/factorial_engine.sv
// Sequential n! unit: one shift-add multiply step per cycle, NW steps per
// factor, saturating to all-ones as soon as the running product overflows.
module factorial_engine #(
  parameter int WIDTH = 32,
  parameter int NW    = 6
) (
  input  logic               clk1,
  input  logic               rst_n,
  factorial_engine_if.slave  bus
);
  localparam int PW = WIDTH + NW;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_CHECK, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [NW-1:0]    k_q, k_d;
  logic [PW-1:0]    p_q, p_d;
  logic [IW-1:0]    i_q, i_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ovf_q, ovf_d;

  logic [PW-1:0]    acc_ext;
  logic [NW-1:0]    k_dec;

  assign acc_ext = {{NW{1'b0}}, acc_q};
  assign k_dec   = k_q - NW'(1);

  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      p_q     <= '0;
      i_q     <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      p_q     <= p_d;
      i_q     <= i_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    k_d     = k_q;
    p_d     = p_q;
    i_d     = i_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          acc_d = WIDTH'(1);
          k_d   = bus.in_n;
          if (bus.in_n < NW'(2)) begin
            res_d   = WIDTH'(1);
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            p_d     = '0;
            i_d     = '0;
            state_d = S_MUL;
          end
        end
      end
      S_MUL: begin
        // Bit i of the current factor selects acc shifted by i into p.
        if (k_q[i_q]) p_d = p_q + (acc_ext << i_q);
        i_d = i_q + IW'(1);
        if (i_q == IW'(NW - 1)) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (|p_q[PW-1:WIDTH]) begin
          res_d   = '1;
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = p_q[WIDTH-1:0];
          k_d   = k_dec;
          if (k_dec == NW'(1)) begin
            res_d   = p_q[WIDTH-1:0];
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            p_d     = '0;
            i_d     = '0;
            state_d = S_MUL;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.in_ready   = (state_q == S_IDLE);
  assign bus.out_valid  = (state_q == S_DONE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.out_result = res_q;
  assign bus.out_ovf    = ovf_q;
endmodule

// File: tb/tb_factorial_engine.sv
// Self-checking bench for factorial_engine: vector table, corner-case
// sequences and random operands against a plain-arithmetic factorial model.
module tb_factorial_engine;
  localparam int WIDTH = 32;
  localparam int NW    = 6;

  logic clk1 = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk1 = ~clk1;

  factorial_engine_if #(.WIDTH(WIDTH), .NW(NW)) bus ();

  factorial_engine #(.WIDTH(WIDTH), .NW(NW)) dut (
    .clk1  (clk1),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          n;
    logic [31:0] res;
    logic        ovf;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // n! from the top down, saturating at the first product that leaves 32 bits.
  // Each factor costs a multiply pass plus a check cycle (NW+1 cycles).
  task automatic model(input int n, output logic [31:0] res, output logic ovf, output int lat);
    longint unsigned acc;
    int steps;
    acc = 1; steps = 0; ovf = 1'b0;
    for (int k = n; k >= 2; k--) begin
      acc = acc * longint'(k);
      steps++;
      if (acc > 64'hFFFF_FFFF) begin
        ovf = 1'b1;
        break;
      end
    end
    res = ovf ? 32'hFFFF_FFFF : acc[31:0];
    lat = (n < 2) ? 1 : steps * (NW + 1) + 1;
  endtask

  // Issue one request, measure accept->out_valid latency, then drain after 'hold' cycles.
  task automatic do_req(input int n, input int hold,
                        output logic [31:0] res, output logic ovf, output int lat);
    int guard;
    logic [NW-1:0] nn;
    nn = NW'(n);
    guard = 0;
    while (!bus.in_ready && guard < 2000) begin @(negedge clk1); guard++; end
    chk("in_ready_before_req", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_n     = nn;
    @(negedge clk1);
    bus.in_valid = 1'b0;
    bus.in_n     = $urandom_range(0, 63);
    lat = 1;
    while (!bus.out_valid && lat < 2000) begin @(negedge clk1); lat++; end
    res = bus.out_result;
    ovf = bus.out_ovf;
    repeat (hold) @(negedge clk1);
    bus.out_ready = 1'b1;
    @(negedge clk1);
    bus.out_ready = 1'b0;
    chk("drain_out_valid", bus.out_valid, 0);
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] r, er;
    logic        o, eo;
    int          l, el;
    string       tag;

    vecs.push_back('{0,  32'd1,          1'b0, 1});
    vecs.push_back('{1,  32'd1,          1'b0, 1});
    vecs.push_back('{2,  32'd2,          1'b0, 8});
    vecs.push_back('{5,  32'd120,        1'b0, 29});
    vecs.push_back('{7,  32'd5040,       1'b0, 43});
    vecs.push_back('{12, 32'd479001600,  1'b0, 78});
    vecs.push_back('{13, 32'hFFFF_FFFF,  1'b1, 85});
    vecs.push_back('{20, 32'hFFFF_FFFF,  1'b1, 57});
    vecs.push_back('{63, 32'hFFFF_FFFF,  1'b1, 43});

    bus.in_valid  = 1'b0;
    bus.in_n      = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk1);
    chk("rst_in_ready",   bus.in_ready,   1);
    chk("rst_out_valid",  bus.out_valid,  0);
    chk("rst_out_result", bus.out_result, 0);
    chk("rst_out_ovf",    bus.out_ovf,    0);
    chk("rst_busy",       bus.busy,       0);
    rst_n = 1'b1;
    @(negedge clk1);

    foreach (vecs[i]) begin
      do_req(vecs[i].n, 0, r, o, l);
      tag = $sformatf("vec_n%0d", vecs[i].n);
      chk({tag, "_res"}, r, vecs[i].res);
      chk({tag, "_ovf"}, o, vecs[i].ovf);
      chk({tag, "_lat"}, l, vecs[i].lat);
    end

    // Result held while the consumer stalls; requests during DONE are dropped.
    do_req(4, 0, r, o, l);
    bus.in_valid = 1'b1; bus.in_n = NW'(3);
    @(negedge clk1);
    bus.in_valid = 1'b0;
    chk("post_req_busy", bus.busy, 1);
    begin
      int g;
      g = 0;
      while (!bus.out_valid && g < 2000) begin @(negedge clk1); g++; end
    end
    chk("hold_first_res", bus.out_result, 6);
    for (int c = 0; c < 20; c++) begin
      if (c == 10) begin bus.in_valid = 1'b1; bus.in_n = NW'(9); end
      if (c == 11) bus.in_valid = 1'b0;
      @(negedge clk1);
      if (c % 5 == 0 || c == 10) begin
        chk("hold_out_valid", bus.out_valid,  1);
        chk("hold_result",    bus.out_result, 6);
        chk("hold_in_ready",  bus.in_ready,   0);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk1);
    bus.out_ready = 1'b0;
    chk("hold_release_valid", bus.out_valid, 0);
    repeat (3) @(negedge clk1);
    chk("hold_no_spurious_busy", bus.busy, 0);

    // Synchronous reset in the middle of a multiply aborts the operation.
    bus.in_valid = 1'b1; bus.in_n = NW'(10);
    @(negedge clk1);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk1);
    chk("pre_rst_busy", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    chk("midrst_in_ready",  bus.in_ready,  1);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_busy",      bus.busy,      0);
    repeat (100) begin
      @(negedge clk1);
      if (bus.out_valid) break;
    end
    chk("midrst_no_result", bus.out_valid, 0);
    do_req(5, 0, r, o, l);
    chk("after_rst_n5", r, 120);

    // Back-to-back requests, results in order.
    for (int j = 3; j <= 5; j++) begin
      do_req(j, 0, r, o, l);
      model(j, er, eo, el);
      chk($sformatf("b2b_n%0d", j), r, er);
    end

    // Random operands with random consumer stalls.
    for (int t = 0; t < 25; t++) begin
      int n;
      n = $urandom_range(0, 63);
      do_req(n, $urandom_range(0, 3), r, o, l);
      model(n, er, eo, el);
      tag = $sformatf("rnd_n%0d", n);
      chk({tag, "_res"}, r, er);
      chk({tag, "_ovf"}, o, eo);
      chk({tag, "_lat"}, l, el);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
